// File: rtl/div_iter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_iter_pkg: shared state encodings and EX-side constants for div_iter  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_iter: multi-cycle radix-2 restoring divider, signed/unsigned         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             stallreq
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] step_rem;

  // Most-negative input maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      DIV_IDLE: begin
        if (start && !annul) begin
          dvs_d     = abs_op(divisor, signed_op);
          quo_d     = abs_op(dividend, signed_op);
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = signed_op & dividend[WIDTH-1];
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DIV_DONE;
          end else begin
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        if (annul) begin
          state_d = DIV_IDLE;
        end else begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            quotient_d  = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
            remainder_d = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
            dbz_d       = 1'b0;
            state_d     = DIV_DONE;
          end
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == DIV_RUN);
  assign done        = (state_q == DIV_DONE) ? DivResultReady : DivResultNotReady;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  // Low in DONE so EX advances and captures the results that cycle.
  assign stallreq    = (((state_q == DIV_IDLE) && start && !annul) || busy) ? DivStart : DivStop;

endmodule
`default_nettype wire

// File: doc/div_iter.md
# div_iter

Parametrised multi-cycle radix-2 integer divider for the EX stage, successor to the fixed 32-bit divider. It accepts signed or unsigned operands of configurable width with a start/annul handshake. It produces quotient and remainder after a fixed latency, flags divide-by-zero, and drives the EX stall request while busy.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- CNT_W, $clog2(WIDTH+1), iteration counter width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request a division; sampled only in IDLE
- annul  in  1  abort the current or requested division (pipeline flush)
- signed_op  in  1  1 = signed (two's complement), 0 = unsigned; captured with start
- dividend  in  WIDTH  operand 1; captured with start
- divisor  in  WIDTH  operand 2; captured with start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when results are valid
- quotient  out  WIDTH  registered quotient (LO)
- remainder  out  WIDTH  registered remainder (HI)
- div_by_zero  out  1  registered; set with done when divisor was 0
- stallreq  out  1  combinational: (IDLE & start & ~annul) | RUN

## Operation
- States: IDLE, RUN, DONE.
- IDLE, with start=1 and annul=0:
  - Capture |dividend| and |divisor|. Absolute value applies only when signed_op=1; the most-negative value maps to 2^(WIDTH-1) unsigned.
  - Capture the sign flags: neg_q = sign(dividend) XOR sign(divisor); neg_r = sign(dividend).
  - Clear the partial remainder and the counter.
  - If divisor==0: go to DONE with quotient = all ones, remainder = raw dividend, div_by_zero=1. Otherwise go to RUN.
- IDLE, with start=1 and annul=1: start is ignored and the state stays IDLE.
- RUN, each cycle, one restoring step:
  - Shift {rem, quo} left one bit.
  - Trial-subtract the divisor from the upper WIDTH+1 bits. If the result is non-negative, keep it and set the quotient LSB.
  - The counter increments.
  - After the WIDTH-th step, go to DONE and register the sign-corrected results: quotient negated if neg_q; remainder negated if neg_r. div_by_zero=0.
- DONE: done=1 for this cycle only. Next state is IDLE unconditionally; start is ignored in DONE.
- annul=1 in RUN: next state is IDLE. No done pulse. quotient, remainder and div_by_zero keep their previous values.
- Overflow, signed most-negative / -1: quotient = most-negative value, remainder = 0, no flag.
- Unsigned mode: no sign correction.
- quotient, remainder and div_by_zero hold their values until the next DONE.

## Timing
- Reset values: state IDLE; busy, done, div_by_zero = 0; quotient and remainder = 0; counter 0.
- rst has priority over annul and start.
- Start sampled in cycle t, normal case:
  - busy is high during cycles t+1 … t+WIDTH.
  - done is high in cycle t+WIDTH+1, with results valid in the same cycle.
  - Latency is WIDTH+1 cycles.
- Start sampled in cycle t, divide-by-zero case: done and results in cycle t+1.
- stallreq:
  - High from the start cycle through the last RUN cycle.
  - Low in DONE, so the EX stage advances in the done cycle and captures the results.
- Back-to-back operation: the earliest next start is accepted in cycle t+WIDTH+2 (IDLE).

## Structure
- Shared package (defines file) holds:
  - The state encodings DIV_IDLE, DIV_RUN, DIV_DONE.
  - The default width constant DIV_WIDTH=32.
  - The DivStart/DivStop and DivResultReady/NotReady constants used by EX.
- No sub-module is required: single FSM plus shift/subtract datapath in one file.
- EX instantiates div_iter in place of the fixed divider. {remainder, quotient} maps to the 64-bit {HI, LO} result.

## Test plan
- Unsigned 100 / 7, WIDTH=32, start at cycle 0 → done at cycle 33; quotient=14, remainder=2; stallreq high in cycles 0–32 and low in cycle 33.
- Signed -7 / 2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 → quotient=-3, remainder=1.
- Divisor 0, dividend 0x1234 → done in cycle 1; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1. A following 9/3 → div_by_zero=0, quotient=3.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned case of the same operands → quotient=0, remainder=0x80000000.
- Annul at RUN step 10 → IDLE next cycle, no done, previous results held. A new 50/5 start then completes with quotient=10 after 33 cycles.
- rst asserted mid-RUN → next cycle IDLE with all outputs 0. Repeat with WIDTH=8: 200/3 unsigned → quotient=66, remainder=2, done 9 cycles after start.
